// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, checks decode and alignment,
// holds the data bus for WAIT_CYCLES cycles, then returns an extended result pulse.
module load_store_unit #(
    parameter int unsigned WAIT_CYCLES     = 1,
    parameter bit          TRAP_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_base,
    input  logic [11:0] req_offset,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [1:0]  resp_cause,
    output logic        bus_rw,
    output logic [1:0]  bus_len,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_write,
    input  logic [31:0] bus_read,
    input  logic        bus_exception
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    localparam logic [3:0] CntInit = 4'(WAIT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        store_q, store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic [1:0]  cause_q, cause_d;

    logic [31:0] ea, ea_aligned, wdata_masked, rdata_ext;
    logic        illegal, misaligned, accept;

    assign accept = req_valid && req_ready;

    // Request decode: effective address, legality, alignment and store data masking.
    always_comb begin
        ea         = req_base + {{20{req_offset[11]}}, req_offset};
        ea_aligned = ea;
        illegal    = 1'b1;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = req_store;
            default:                illegal = 1'b1;
        endcase
        misaligned = 1'b0;
        case (req_funct3[1:0])
            2'b01: begin
                misaligned    = ea[0];
                ea_aligned[0] = 1'b0;
            end
            2'b10: begin
                misaligned      = (ea[1:0] != 2'b00);
                ea_aligned[1:0] = 2'b00;
            end
            default: ;
        endcase
        wdata_masked = 32'd0;
        if (req_store) begin
            case (req_funct3[1:0])
                2'b00:   wdata_masked = {24'd0, req_wdata[7:0]};
                2'b01:   wdata_masked = {16'd0, req_wdata[15:0]};
                default: wdata_masked = req_wdata;
            endcase
        end
    end

    always_comb begin
        case (funct3_q)
            3'b000:  rdata_ext = {{24{bus_read[7]}}, bus_read[7:0]};
            3'b001:  rdata_ext = {{16{bus_read[15]}}, bus_read[15:0]};
            3'b010:  rdata_ext = bus_read;
            3'b100:  rdata_ext = {24'd0, bus_read[7:0]};
            3'b101:  rdata_ext = {16'd0, bus_read[15:0]};
            default: rdata_ext = 32'd0;
        endcase
        if (store_q) begin
            rdata_ext = 32'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            store_q  <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            fault_q  <= 1'b0;
            cause_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            store_q  <= store_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
            cause_q  <= cause_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        store_d  = store_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        fault_d  = fault_q;
        cause_d  = cause_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    store_d  = req_store;
                    funct3_d = req_funct3;
                    addr_d   = ea_aligned;
                    wdata_d  = wdata_masked;
                    rdata_d  = 32'd0;
                    fault_d  = 1'b0;
                    cause_d  = 2'd0;
                    cnt_d    = CntInit;
                    if (illegal) begin
                        fault_d = 1'b1;
                        cause_d = 2'd3;
                        state_d = StResp;
                    end else if (misaligned && TRAP_MISALIGNED) begin
                        fault_d = 1'b1;
                        cause_d = 2'd1;
                        state_d = StResp;
                    end else begin
                        state_d = StAccess;
                    end
                end
            end
            StAccess: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                    if (bus_exception) begin
                        fault_d = 1'b1;
                        cause_d = 2'd2;
                        rdata_d = 32'd0;
                    end else begin
                        rdata_d = rdata_ext;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'd0;
        resp_fault = 1'b0;
        resp_cause = 2'd0;
        bus_rw     = 1'b0;
        bus_len    = 2'd0;
        bus_addr   = 32'd0;
        bus_write  = 32'd0;
        case (state_q)
            // Idle is also the reset state, so hold ready low while reset is asserted.
            StIdle: req_ready = ~rst;
            StAccess: begin
                bus_rw    = store_q;
                bus_len   = funct3_q[1:0];
                bus_addr  = addr_q;
                bus_write = wdata_q;
            end
            StResp: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_fault = fault_q;
                resp_cause = cause_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (WAIT=1/trap, WAIT=4/no-trap) share stimulus
// and are checked every cycle against a transaction-level model plus literal expectations.
module tb_load_store_unit;

    localparam int WA = 1;
    localparam int WB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_store, bus_exception;
    logic [2:0]  req_funct3;
    logic [31:0] req_base, req_wdata, bus_read;
    logic [11:0] req_offset;

    logic        a_req_ready, a_resp_valid, a_resp_fault, a_bus_rw;
    logic [31:0] a_resp_rdata, a_bus_addr, a_bus_write;
    logic [1:0]  a_resp_cause, a_bus_len;
    logic        b_req_ready, b_resp_valid, b_resp_fault, b_bus_rw;
    logic [31:0] b_resp_rdata, b_bus_addr, b_bus_write;
    logic [1:0]  b_resp_cause, b_bus_len;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.WAIT_CYCLES(WA), .TRAP_MISALIGNED(1'b1)) u_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_req_ready),
        .req_store(req_store), .req_funct3(req_funct3), .req_base(req_base),
        .req_offset(req_offset), .req_wdata(req_wdata), .resp_valid(a_resp_valid),
        .resp_rdata(a_resp_rdata), .resp_fault(a_resp_fault), .resp_cause(a_resp_cause),
        .bus_rw(a_bus_rw), .bus_len(a_bus_len), .bus_addr(a_bus_addr),
        .bus_write(a_bus_write), .bus_read(bus_read), .bus_exception(bus_exception)
    );

    load_store_unit #(.WAIT_CYCLES(WB), .TRAP_MISALIGNED(1'b0)) u_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_req_ready),
        .req_store(req_store), .req_funct3(req_funct3), .req_base(req_base),
        .req_offset(req_offset), .req_wdata(req_wdata), .resp_valid(b_resp_valid),
        .resp_rdata(b_resp_rdata), .resp_fault(b_resp_fault), .resp_cause(b_resp_cause),
        .bus_rw(b_bus_rw), .bus_len(b_bus_len), .bus_addr(b_bus_addr),
        .bus_write(b_bus_write), .bus_read(bus_read), .bus_exception(bus_exception)
    );

    logic [103:0] act [2];
    assign act[0] = {a_req_ready, a_bus_rw, a_bus_len, a_bus_addr, a_bus_write,
                     a_resp_valid, a_resp_rdata, a_resp_fault, a_resp_cause};
    assign act[1] = {b_req_ready, b_bus_rw, b_bus_len, b_bus_addr, b_bus_write,
                     b_resp_valid, b_resp_rdata, b_resp_fault, b_resp_cause};

    // ---------------- transaction model ----------------
    typedef struct packed {
        logic        acc;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] wr;
        logic [1:0]  cause;
    } exp_t;

    function automatic int wt(input int i);
        return (i == 0) ? WA : WB;
    endfunction

    function automatic exp_t decode(input logic st, input logic [2:0] f3, input logic [31:0] base,
                                    input logic [11:0] off, input logic [31:0] wd, input bit trap);
        exp_t e;
        bit legal;
        int unsigned size;
        logic [31:0] rem;
        e = '0;
        e.st = st;
        e.f3 = f3;
        e.addr = base + 32'(int'($signed(off)));
        if (st) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        else    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (!legal) begin
            e.cause = 2'd3;
            return e;
        end
        size = 1 << f3[1:0];
        rem = e.addr % size;
        if (rem != 0) begin
            if (trap) begin
                e.cause = 2'd1;
                return e;
            end
            e.addr = e.addr - rem;
        end
        e.acc = 1'b1;
        e.len = f3[1:0];
        e.wr = st ? (wd & 32'((64'd1 << (8 * size)) - 64'd1)) : 32'd0;
        return e;
    endfunction

    function automatic logic [31:0] ext(input logic [2:0] f3, input logic [31:0] rd);
        int v;
        case (f3)
            3'd0: v = (rd % 256 >= 128) ? int'(rd % 256) - 256 : int'(rd % 256);
            3'd1: v = (rd % 65536 >= 32768) ? int'(rd % 65536) - 65536 : int'(rd % 65536);
            3'd4: v = int'(rd % 256);
            3'd5: v = int'(rd % 65536);
            default: v = int'(rd);
        endcase
        return 32'(v);
    endfunction

    int          m_k   [2];
    exp_t        m_e   [2];
    logic [31:0] m_rd  [2];
    logic        m_exc [2];

    // m_k counts cycles since accept (0 = idle).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) m_k[i] <= 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_k[i] == 0) begin
                    if (req_valid) begin
                        m_k[i] <= 1;
                        m_e[i] <= decode(req_store, req_funct3, req_base, req_offset,
                                         req_wdata, i == 0);
                    end
                end else if (!m_e[i].acc || m_k[i] == wt(i) + 1) begin
                    m_k[i] <= 0;
                end else begin
                    if (m_k[i] == wt(i)) begin
                        m_rd[i]  <= m_e[i].st ? 32'd0 : ext(m_e[i].f3, bus_read);
                        m_exc[i] <= bus_exception;
                    end
                    m_k[i] <= m_k[i] + 1;
                end
            end
        end
    end

    function automatic logic [103:0] expv(input int i);
        logic        rdy, rw, rv, flt;
        logic [1:0]  len, cause;
        logic [31:0] addr, wr, rd;
        {rdy, rw, rv, flt, len, cause, addr, wr, rd} = '0;
        if (m_k[i] == 0) begin
            rdy = !rst;
        end else if (m_e[i].acc && m_k[i] <= wt(i)) begin
            rw   = m_e[i].st;
            len  = m_e[i].len;
            addr = m_e[i].addr;
            wr   = m_e[i].wr;
        end else begin
            rv = 1'b1;
            if (m_e[i].acc) begin
                flt   = m_exc[i];
                cause = m_exc[i] ? 2'd2 : 2'd0;
                rd    = m_exc[i] ? 32'd0 : m_rd[i];
            end else begin
                flt   = 1'b1;
                cause = m_e[i].cause;
            end
        end
        return {rdy, rw, len, addr, wr, rv, rd, flt, cause};
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            total++;
            if (act[i] !== expv(i)) begin
                bad++;
                $display("FAIL model dut%0d k=%0d got=%h exp=%h", i, m_k[i], act[i], expv(i));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Presents a request for one cycle; returns at the negedge of the first cycle after accept.
    task automatic start(input logic st, input logic [2:0] f3, input logic [31:0] base,
                         input logic [11:0] off, input logic [31:0] wd, input logic [31:0] rd,
                         input logic exc);
        @(negedge clk);
        req_store = st; req_funct3 = f3; req_base = base; req_offset = off;
        req_wdata = wd; bus_read = rd; bus_exception = exc; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!(a_req_ready && b_req_ready) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", 32'(n < 60), 32'd1);
    endtask

    int a_t[$];
    int b_t[$];

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0; req_base = '0;
        req_offset = '0; req_wdata = '0; bus_read = '0; bus_exception = 1'b0;
        #1;
        chk("rst_ready_low", 32'(a_req_ready), 32'd0);
        chk("rst_resp_valid", 32'(a_resp_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("ready_after_rst", 32'(a_req_ready), 32'd1);

        // LW 0x100+4
        start(1'b0, 3'b010, 32'h100, 12'h004, 32'h0, 32'hDEADBEEF, 1'b0);
        chk("lw_addr", a_bus_addr, 32'h104);
        chk("lw_len", 32'(a_bus_len), 32'd2);
        chk("lw_rw", 32'(a_bus_rw), 32'd0);
        chk("lw_ready_busy", 32'(a_req_ready), 32'd0);
        @(negedge clk);
        chk("lw_resp_valid", 32'(a_resp_valid), 32'd1);
        chk("lw_rdata", a_resp_rdata, 32'hDEADBEEF);
        chk("lw_fault", 32'(a_resp_fault), 32'd0);
        wait_idle();

        // LB / LBU sign vs zero extension
        start(1'b0, 3'b000, 32'h200, 12'h000, 32'h0, 32'h00000080, 1'b0);
        @(negedge clk);
        chk("lb_rdata", a_resp_rdata, 32'hFFFFFF80);
        wait_idle();
        start(1'b0, 3'b100, 32'h200, 12'h000, 32'h0, 32'h00000080, 1'b0);
        @(negedge clk);
        chk("lbu_rdata", a_resp_rdata, 32'h00000080);
        wait_idle();
        start(1'b0, 3'b001, 32'h200, 12'h000, 32'h0, 32'h1234_9ABC, 1'b0);
        @(negedge clk);
        chk("lh_rdata", a_resp_rdata, 32'hFFFF9ABC);
        wait_idle();

        // SH with negative offset
        start(1'b1, 3'b001, 32'h10, 12'hFFE, 32'h12345678, 32'hFFFFFFFF, 1'b0);
        chk("sh_addr", a_bus_addr, 32'h0E);
        chk("sh_rw", 32'(a_bus_rw), 32'd1);
        chk("sh_len", 32'(a_bus_len), 32'd1);
        chk("sh_write", a_bus_write, 32'h00005678);
        @(negedge clk);
        chk("sh_rdata", a_resp_rdata, 32'd0);
        chk("sh_fault", 32'(a_resp_fault), 32'd0);
        wait_idle();

        // Misaligned LW: trap on a, forced alignment on b
        start(1'b0, 3'b010, 32'h102, 12'h000, 32'h0, 32'h11111111, 1'b0);
        chk("mis_rw", 32'(a_bus_rw), 32'd0);
        chk("mis_valid", 32'(a_resp_valid), 32'd1);
        chk("mis_fault", 32'(a_resp_fault), 32'd1);
        chk("mis_cause", 32'(a_resp_cause), 32'd1);
        chk("mis_noTrap_addr", b_bus_addr, 32'h100);
        wait_idle();

        // Bus exception
        start(1'b0, 3'b010, 32'h100, 12'h000, 32'h0, 32'hDEADBEEF, 1'b1);
        @(negedge clk);
        chk("exc_fault", 32'(a_resp_fault), 32'd1);
        chk("exc_cause", 32'(a_resp_cause), 32'd2);
        chk("exc_rdata", a_resp_rdata, 32'd0);
        wait_idle();

        // Illegal funct3 load
        start(1'b0, 3'b011, 32'h100, 12'h000, 32'h0, 32'hDEADBEEF, 1'b0);
        chk("ill_cause", 32'(a_resp_cause), 32'd3);
        chk("ill_b_cause", 32'(b_resp_cause), 32'd3);
        chk("ill_b_len", 32'(b_bus_len), 32'd0);
        wait_idle();

        // Reset in the middle of b's ACCESS phase
        start(1'b0, 3'b010, 32'h100, 12'h000, 32'h0, 32'hCAFEF00D, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_addr", b_bus_addr, 32'd0);
        chk("mid_rst_valid", 32'(b_resp_valid), 32'd0);
        chk("mid_rst_ready", 32'(b_req_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("post_rst_ready", 32'(b_req_ready), 32'd1);

        // Held request: accepted every WAIT+2 cycles
        @(negedge clk);
        req_store = 1'b0; req_funct3 = 3'b010; req_base = 32'h100; req_offset = 12'h0;
        bus_read = 32'h0BADF00D; bus_exception = 1'b0; req_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (a_resp_valid) a_t.push_back(c);
            if (b_resp_valid) b_t.push_back(c);
        end
        req_valid = 1'b0;
        chk("b2b_a_p0", 32'((a_t.size() >= 3) ? a_t[1] - a_t[0] : -1), 32'(WA + 2));
        chk("b2b_a_p1", 32'((a_t.size() >= 3) ? a_t[2] - a_t[1] : -1), 32'(WA + 2));
        chk("b2b_b_p0", 32'((b_t.size() >= 3) ? b_t[1] - b_t[0] : -1), 32'(WB + 2));
        chk("b2b_b_p1", 32'((b_t.size() >= 3) ? b_t[2] - b_t[1] : -1), 32'(WB + 2));
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
